// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: tiny8_types package with ALU opcodes and the seq_alu FSM state type.
package tiny8_types;
  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sub = 3'd1,
    alu_dec = 3'd2,
    alu_mul = 3'd3
  } tiny8_aluop;
  typedef logic [7:0] tiny8_word;
  typedef enum logic [1:0] {IDLE, MUL, DONE} seq_alu_state_t;
endpackage

// File: rtl/seq_alu_mul_step.sv
// seq_alu_mul_step: one combinational shift-add multiply iteration.
// The overflow output exists only when SEQ_ALU_FLAGS_EN is defined.
module seq_alu_mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0] o_mplier
`ifdef SEQ_ALU_FLAGS_EN
  , output logic o_ovf
`endif
);
  always_comb begin
`ifdef SEQ_ALU_FLAGS_EN
    {o_ovf, o_acc} = i_mplier[0] ? {1'b0, i_acc} + {1'b0, i_mcand} : {1'b0, i_acc};
`else
    o_acc = i_mplier[0] ? i_acc + i_mcand : i_acc;
`endif
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle add/sub/dec/mul ALU with valid/ready on both sides.
// Optional zero/carry flag outputs are enabled by SEQ_ALU_FLAGS_EN.
module seq_alu
  import tiny8_types::*;
#(
  parameter int WIDTH    = 8,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  tiny8_aluop       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             illegal
`ifdef SEQ_ALU_FLAGS_EN
  , output logic           zero
  , output logic           carry
`endif
);
  localparam int CW = $clog2(MUL_BITS) + 1;
`ifdef SEQ_ALU_FLAGS_EN
  localparam int XW = WIDTH + 1;
`else
  localparam int XW = WIDTH;
`endif

  seq_alu_state_t   r_state;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc, w_mcand, w_mplier;
  logic [XW-1:0]    w_ext;
  logic             w_ill, w_accept, w_last;
`ifdef SEQ_ALU_FLAGS_EN
  logic             r_ovf, w_ovf;
`endif

  assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_last   = r_cnt == CW'(MUL_BITS - 1);
  assign w_ill    = !(aluop inside {alu_add, alu_sub, alu_dec, alu_mul});
  // With flags the extra top bit is the add carry-out or the sub/dec borrow
  assign w_ext = aluop == alu_add ? XW'(a) + XW'(b) :
                 aluop == alu_sub ? XW'(a) - XW'(b) :
                 aluop == alu_dec ? XW'(a) - XW'(1) : '0;

  seq_alu_mul_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplier(r_mplier),
    .o_acc   (w_acc),
    .o_mcand (w_mcand),
    .o_mplier(w_mplier)
`ifdef SEQ_ALU_FLAGS_EN
    , .o_ovf (w_ovf)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      f         <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
`ifdef SEQ_ALU_FLAGS_EN
      r_ovf     <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
`endif
    end else if (w_accept && aluop == alu_mul) begin
      r_state   <= MUL;
      out_valid <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= a;
      r_mplier  <= WIDTH'(b[MUL_BITS-1:0]);
      r_cnt     <= '0;
`ifdef SEQ_ALU_FLAGS_EN
      r_ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state   <= DONE;
      out_valid <= 1'b1;
      f         <= w_ext[WIDTH-1:0];
      illegal   <= w_ill;
`ifdef SEQ_ALU_FLAGS_EN
      zero      <= w_ext[WIDTH-1:0] == '0;
      carry     <= w_ext[WIDTH];
`endif
    end else if (r_state == MUL) begin
      r_acc     <= w_acc;
      r_mcand   <= w_mcand;
      r_mplier  <= w_mplier;
      r_cnt     <= r_cnt + CW'(1);
`ifdef SEQ_ALU_FLAGS_EN
      r_ovf     <= r_ovf | w_ovf;
`endif
      if (w_last) begin
        r_state   <= DONE;
        out_valid <= 1'b1;
        f         <= w_acc;
        illegal   <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
        zero      <= w_acc == '0;
        carry     <= r_ovf | w_ovf;
`endif
      end
    end else if (r_state == DONE && out_ready) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the tiny8 combinational ALU.
- Implements add/sub/dec/mul over WIDTH-bit operands.
- Multiply is a one-bit-per-cycle shift-add iteration instead of an unrolled adder chain.
- Sits between operand fetch and writeback, with valid/ready handshakes on both sides so the datapath can stall cleanly.

Parameters:
- WIDTH, 8: operand/result width in bits.
- MUL_BITS, 4: number of low bits of b used as the multiplier; also the mul iteration count; legal range 1..WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on rising clk.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- aluop  in  tiny8_aluop  operation select.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- out_valid  out  1  result held on f.
- out_ready  in  1  consumer takes result this cycle.
- f  out  WIDTH  result.
- illegal  out  1  qualifies f; high when the completed op was an unknown aluop.
- zero, carry  out  1 each  present only with SEQ_ALU_FLAGS_EN.

Behaviour:
- FSM states: IDLE, MUL, DONE.
- Reset (rst_n=0 at edge), from any state including mid-multiply:
  - state=IDLE; f=0; out_valid=0; illegal=0; zero=0; carry=0.
  - Multiply accumulator, shifted multiplicand and counter cleared.
  - In-flight op discarded.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no path from in_valid to in_ready.
- Accept = in_valid && in_ready. a, b and aluop are captured at accept; later input changes are ignored.
- add, sub, dec: result computed in the accept cycle and registered. Go to DONE; out_valid=1 the next cycle (latency 1).
  - add: f = a+b mod 2^WIDTH.
  - sub: f = a-b mod 2^WIDTH.
  - dec: f = a-1 mod 2^WIDTH; 0 wraps to all-ones.
- mul, at accept:
  - acc=0, mcand=a, mplier=b[MUL_BITS-1:0], cnt=0; go to MUL.
- mul, each MUL cycle:
  - If mplier[0], acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches MUL_BITS-1 in that cycle: f=updated acc, go to DONE.
  - Total latency MUL_BITS cycles from accept to out_valid.
  - No early termination; latency fixed regardless of operand values.
  - Result is the low WIDTH bits of a*b[MUL_BITS-1:0].
- Unknown aluop: f=0, illegal=1, latency 1 (treated as a single-cycle op). No simulation-only print.
- DONE state:
  - f and illegal stay stable while out_valid && !out_ready.
  - On out_ready with no accept: go to IDLE, out_valid=0.
  - On out_ready with a simultaneous accept (back-to-back): the new op starts that edge.
    - New single-cycle op: out_valid stays 1 with the new f.
    - New mul: out_valid drops while iterating.
- out_valid never asserts in IDLE or MUL.

Optional Feature:
- Macro name: SEQ_ALU_FLAGS_EN.
- Defined: zero and carry ports exist, registered alongside f.
  - zero = (f==0).
  - carry:
    - add: carry-out of bit WIDTH-1.
    - sub/dec: borrow (a<b unsigned; for dec, a==0).
    - mul: 1 if any accumulation step overflowed.
    - illegal: 0.
- Undefined: the ports are absent and no flag logic is generated. f, latency and handshake are identical either way.

Decomposition:
- tiny8_types package holds:
  - tiny8_aluop (existing alu_add/alu_sub/alu_dec/alu_mul); seq_alu uses the type but not tiny8_word, since its width is WIDTH.
  - New seq_alu_state_t enum {IDLE, MUL, DONE}.
- One sub-module, seq_alu_mul_step: combinational single iteration.
  - Inputs: acc, mcand, mplier; outputs: next acc, mcand, mplier and an overflow bit.
  - Parametrised by WIDTH.
- FSM and handshake stay in seq_alu.

Test Plan:
- WIDTH=8, reset held 2 cycles -> f=0, out_valid=0, in_ready=1. Then add a=0xF0 b=0x20 with out_ready=1 -> out_valid next cycle, f=0x10, carry=1 with flags.
- dec a=0x00 -> f=0xFF, illegal=0. Then sub a=3 b=5 -> f=0xFE, carry=1.
- mul a=0x07 b=0xFD (MUL_BITS=4, low nibble 0xD) -> out_valid exactly 4 cycles after accept, f=0x5B. in_ready=0 during MUL.
- Backpressure: add 1+1 with out_ready=0 for 5 cycles -> f=0x02 held and in_ready=0 throughout. Release out_ready with in_valid=1 add 2+2 -> next cycle f=0x04 with out_valid continuously 1.
- Reset mid-mul: assert rst_n=0 on the 2nd MUL cycle -> next cycle state IDLE, out_valid=0, and no stale result emitted afterwards.
- Illegal aluop encoding -> f=0, illegal=1 after 1 cycle; next legal op clears illegal.
